// File: rtl/load_store_unit.sv
// Load/store unit: accepts one access at a time, checks alignment and range,
// and performs big-endian sub-word loads and read-modify-write sub-word stores.
module load_store_unit #(
  parameter int WORD_SIZE   = 32,
  parameter int MEMORY_SIZE = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_signed,
  input  logic [WORD_SIZE-1:0] req_address,
  input  logic [WORD_SIZE-1:0] req_data,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 err_misaligned,
  output logic                 err_invalid_address,
  output logic [WORD_SIZE-1:0] mem_address,
  output logic                 mem_read_enabled,
  output logic                 mem_write_enabled,
  output logic [WORD_SIZE-1:0] mem_write_data,
  input  logic [WORD_SIZE-1:0] mem_read_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [WORD_SIZE-1:0] LP_MAX_IDX = WORD_SIZE'(MEMORY_SIZE - 1);

  logic [1:0]           r_state;
  logic                 r_write;
  logic [1:0]           r_size;
  logic                 r_signed;
  logic [WORD_SIZE-1:0] r_addr;
  logic [WORD_SIZE-1:0] r_data;
  logic [WORD_SIZE-1:0] r_word;
  logic [WORD_SIZE-1:0] r_resp_data;
  logic                 r_err_mis;
  logic                 r_err_inv;

  logic                 w_misaligned;
  logic                 w_invalid;
  logic [4:0]           w_byte_sh;
  logic [4:0]           w_half_sh;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [WORD_SIZE-1:0] w_load;
  logic [WORD_SIZE-1:0] w_mask;
  logic [WORD_SIZE-1:0] w_lane;
  logic [WORD_SIZE-1:0] w_merged;

  assign w_misaligned = (req_size == 2'b11)
                      | ((req_size == SZ_HALF) & req_address[0])
                      | ((req_size == SZ_WORD) & (|req_address[1:0]));
  assign w_invalid    = (req_address >> 2) > LP_MAX_IDX;

  // Big-endian lanes: offset 0 is the most significant byte/halfword.
  assign w_byte_sh = {~r_addr[1:0], 3'b000};
  assign w_half_sh = {~r_addr[1], 4'b0000};
  assign w_byte    = 8'(mem_read_data >> w_byte_sh);
  assign w_half    = 16'(mem_read_data >> w_half_sh);

  always_comb begin
    w_load = mem_read_data;
    case (r_size)
      SZ_BYTE: w_load = r_signed ? {{(WORD_SIZE-8){w_byte[7]}}, w_byte}
                                 : {{(WORD_SIZE-8){1'b0}}, w_byte};
      SZ_HALF: w_load = r_signed ? {{(WORD_SIZE-16){w_half[15]}}, w_half}
                                 : {{(WORD_SIZE-16){1'b0}}, w_half};
      default: w_load = mem_read_data;
    endcase
  end

  always_comb begin
    w_mask = '0;
    w_lane = '0;
    if (r_size == SZ_HALF) begin
      w_mask = WORD_SIZE'(16'hFFFF) << w_half_sh;
      w_lane = WORD_SIZE'(r_data[15:0]) << w_half_sh;
    end else begin
      w_mask = WORD_SIZE'(8'hFF) << w_byte_sh;
      w_lane = WORD_SIZE'(r_data[7:0]) << w_byte_sh;
    end
    w_merged = (r_word & ~w_mask) | w_lane;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_write     <= 1'b0;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_word      <= '0;
      r_resp_data <= '0;
      r_err_mis   <= 1'b0;
      r_err_inv   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_write     <= req_write;
          r_size      <= req_size;
          r_signed    <= req_signed;
          r_addr      <= req_address;
          r_data      <= req_data;
          r_resp_data <= '0;
          // Misalignment wins when the address is also out of range.
          r_err_mis   <= w_misaligned;
          r_err_inv   <= ~w_misaligned & w_invalid;
          if (w_misaligned | w_invalid)             r_state <= S_RESP;
          else if (req_write && req_size == SZ_WORD) r_state <= S_WRITE;
          else                                      r_state <= S_READ;
        end
        S_READ: begin
          r_word <= mem_read_data;
          if (r_write) begin
            r_state <= S_WRITE;
          end else begin
            r_resp_data <= w_load;
            r_state     <= S_RESP;
          end
        end
        S_WRITE: r_state <= S_RESP;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready           = (r_state == S_IDLE);
  assign mem_read_enabled    = (r_state == S_READ);
  assign mem_write_enabled   = (r_state == S_WRITE);
  assign mem_address         = (r_state == S_IDLE) ? '0 : (r_addr >> 2);
  assign mem_write_data      = (r_state != S_WRITE) ? '0
                             : (r_size == SZ_WORD)  ? r_data : w_merged;
  assign resp_valid          = (r_state == S_RESP);
  assign resp_data           = resp_valid ? r_resp_data : '0;
  assign err_misaligned      = resp_valid & r_err_mis;
  assign err_invalid_address = resp_valid & r_err_inv;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural memory and an
// expected-response queue checked as each response pulse appears.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_data;
  logic        resp_valid, err_misaligned, err_invalid_address;
  logic [31:0] resp_data, mem_address, mem_write_data, mem_read_data;
  logic        mem_read_enabled, mem_write_enabled;

  logic [31:0] mem [0:1023];
  logic        tb_we;
  logic [9:0]  tb_idx;
  logic [31:0] tb_wd;

  typedef struct {
    logic [31:0] data;
    logic        mis;
    logic        inv;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] wa;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_pass = 0;
  int n_acc = 0, n_resp = 0, n_both = 0, n_bad_rdy = 0;

  load_store_unit #(.WORD_SIZE(32), .MEMORY_SIZE(1024)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_address(req_address),
    .req_data(req_data), .resp_valid(resp_valid), .resp_data(resp_data),
    .err_misaligned(err_misaligned), .err_invalid_address(err_invalid_address),
    .mem_address(mem_address), .mem_read_enabled(mem_read_enabled),
    .mem_write_enabled(mem_write_enabled), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  always #5 clock = ~clock;

  assign mem_read_data = (mem_address < 32'd1024) ? mem[mem_address[9:0]] : 32'h0;

  always @(posedge clock) begin
    if (mem_write_enabled && mem_address < 32'd1024) mem[mem_address[9:0]] <= mem_write_data;
    else if (tb_we) mem[tb_idx] <= tb_wd;
  end

  always @(posedge clock) if (!reset && req_valid && req_ready) n_acc++;
  always @(negedge clock) begin
    if (resp_valid) n_resp++;
    if (mem_read_enabled && mem_write_enabled) n_both++;
    if (req_ready && (mem_read_enabled || mem_write_enabled || resp_valid)) n_bad_rdy++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clock);
    tb_we = 1'b1; tb_idx = idx; tb_wd = val;
    @(posedge clock);
    #1 tb_we = 1'b0;
  endtask

  task automatic xact(input string tag, input logic w, input logic [1:0] sz,
                      input logic sg, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] edata, input logic emis, input logic einv,
                      input int elat, input int erd, input int ewr, input logic [31:0] ewa);
    exp_t e;
    int rd = 0, wr = 0, lat = 0;
    logic [31:0] wa = 32'h0, rdat = 32'h0;
    logic rmis = 1'b0, rinv = 1'b0;
    e.data = edata; e.mis = emis; e.inv = einv; e.lat = elat;
    e.rd = erd; e.wr = ewr; e.wa = ewa;
    sb.push_back(e);
    @(negedge clock);
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_address = a; req_data = d;
    @(posedge clock);
    // Scramble inputs after accept so only latched values can matter.
    #1 req_valid = 1'b0;
    req_address = $urandom; req_data = $urandom;
    req_write = ~w; req_size = ~sz; req_signed = ~sg;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (mem_read_enabled) rd++;
      if (mem_write_enabled) begin wr++; wa = mem_address; end
      if (resp_valid) begin
        lat = k; rdat = resp_data; rmis = err_misaligned; rinv = err_invalid_address;
        break;
      end
    end
    e = sb.pop_front();
    chk({tag, ".lat"},  32'(lat),  32'(e.lat));
    chk({tag, ".data"}, rdat,      e.data);
    chk({tag, ".mis"},  32'(rmis), 32'(e.mis));
    chk({tag, ".inv"},  32'(rinv), 32'(e.inv));
    chk({tag, ".rd"},   32'(rd),   32'(e.rd));
    chk({tag, ".wr"},   32'(wr),   32'(e.wr));
    if (e.wr > 0) chk({tag, ".waddr"}, wa, e.wa);
  endtask

  initial begin
    int a0, r0;
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_signed = 1'b0; req_address = 32'h0; req_data = 32'h0;
    tb_we = 1'b0; tb_idx = 10'h0; tb_wd = 32'h0;
    #12;
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp",  32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_data, 32'h0);
    chk("rst.strb",  32'({mem_read_enabled, mem_write_enabled}), 32'd0);
    chk("rst.maddr", mem_address, 32'h0);
    chk("rst.wdata", mem_write_data, 32'h0);
    @(negedge clock); reset = 1'b0;

    // Word store then word load
    xact("wst",  1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0, 2, 0, 1, 32'd4);
    chk("wst.mem", mem[4], 32'hDEADBEEF);
    xact("wld",  0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 2, 1, 0, 32'd0);

    // Sub-word stores merge into the existing word
    preload(10'd4, 32'h11223344);
    xact("bst",  1, 2'b00, 0, 32'h11, 32'h123456AA, 32'h0, 0, 0, 3, 1, 1, 32'd4);
    chk("bst.mem", mem[4], 32'h11AA3344);
    preload(10'd5, 32'h01020304);
    xact("hst",  1, 2'b01, 0, 32'h16, 32'hFFFFBEEF, 32'h0, 0, 0, 3, 1, 1, 32'd5);
    chk("hst.mem", mem[5], 32'h0102BEEF);

    // Extraction and extension
    preload(10'd4, 32'h80FF7F01);
    xact("lbs0", 0, 2'b00, 1, 32'h10, 32'h0, 32'hFFFFFF80, 0, 0, 2, 1, 0, 32'd0);
    xact("lhu2", 0, 2'b01, 0, 32'h12, 32'h0, 32'h00007F01, 0, 0, 2, 1, 0, 32'd0);
    xact("lhs0", 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFF80FF, 0, 0, 2, 1, 0, 32'd0);
    xact("lbu1", 0, 2'b00, 0, 32'h11, 32'h0, 32'h000000FF, 0, 0, 2, 1, 0, 32'd0);
    xact("lbs1", 0, 2'b00, 1, 32'h11, 32'h0, 32'hFFFFFFFF, 0, 0, 2, 1, 0, 32'd0);
    xact("lbs3", 0, 2'b00, 1, 32'h13, 32'h0, 32'h00000001, 0, 0, 2, 1, 0, 32'd0);
    xact("lbs2", 0, 2'b00, 1, 32'h12, 32'h0, 32'h0000007F, 0, 0, 2, 1, 0, 32'd0);

    // Errors and range boundary
    xact("emish", 0, 2'b01, 0, 32'h13,   32'h0, 32'h0, 1, 0, 1, 0, 0, 32'd0);
    xact("einv",  1, 2'b10, 0, 32'h1000, 32'h5, 32'h0, 0, 1, 1, 0, 0, 32'd0);
    xact("esz3",  0, 2'b11, 0, 32'h10,   32'h0, 32'h0, 1, 0, 1, 0, 0, 32'd0);
    xact("emisw", 1, 2'b10, 0, 32'h12,   32'h7, 32'h0, 1, 0, 1, 0, 0, 32'd0);
    xact("eboth", 0, 2'b10, 0, 32'h1001, 32'h0, 32'h0, 1, 0, 1, 0, 0, 32'd0);
    xact("einvb", 0, 2'b00, 0, 32'h1003, 32'h0, 32'h0, 0, 1, 1, 0, 0, 32'd0);
    preload(10'd1023, 32'hCAFEF00D);
    xact("last",  0, 2'b10, 0, 32'hFFC,  32'h0, 32'hCAFEF00D, 0, 0, 2, 1, 0, 32'd0);

    // req_valid held high across two loads: one accept per transaction
    @(negedge clock);
    a0 = n_acc; r0 = n_resp;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_address = 32'h10;
    repeat (6) @(posedge clock);
    #1 req_valid = 1'b0;
    chk("b2b.acc",  32'(n_acc - a0),  32'd2);
    chk("b2b.resp", 32'(n_resp - r0), 32'd2);

    // Reset during a word store aborts the write
    preload(10'd8, 32'h00000055);
    @(negedge clock);
    r0 = n_resp;
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_address = 32'h20;
    req_data = 32'h12345678;
    @(posedge clock);
    #1 req_valid = 1'b0;
    chk("rw.wen", 32'(mem_write_enabled), 32'd1);
    reset = 1'b1;
    #1;
    chk("rw.wdrop", 32'(mem_write_enabled), 32'd0);
    chk("rw.ready", 32'(req_ready), 32'd1);
    chk("rw.maddr", mem_address, 32'h0);
    @(negedge clock); reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rw.noresp", 32'(n_resp - r0), 32'd0);
    chk("rw.mem", mem[8], 32'h00000055);

    chk("glob.both",  32'(n_both), 32'd0);
    chk("glob.ready", 32'(n_bad_rdy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
